// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle data memory controller with byte/half/word loads and stores
// Optional DMEM_MISALIGN_CHK_EN: flag misaligned accesses instead of forcing alignment.
module data_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 17,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int LATENCY        = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MemWriteM,
  input  logic                    MemReadM,
  input  logic [DATA_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  input  logic [FUNCT3_WIDTH-1:0] funct3M,
  output logic [DATA_WIDTH-1:0]   ReadDataM,
  output logic                    StallMem,
  output logic                    MemErrM
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int IDXW  = MEM_ADDR_WIDTH - OFFW;
  localparam int DEPTH = 1 << IDXW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  function automatic logic [1:0] size_of(input logic [FUNCT3_WIDTH-1:0] f3);
    if (f3 == FUNCT3_WIDTH'(0) || f3 == FUNCT3_WIDTH'(4)) return SZ_BYTE;
    if (f3 == FUNCT3_WIDTH'(1) || f3 == FUNCT3_WIDTH'(5)) return SZ_HALF;
    return SZ_WORD;
  endfunction

  logic [1:0]                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [FUNCT3_WIDTH-1:0]   f3_q, f3_d;
  logic                      store_q, store_d;
  logic                      load_q, load_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      mem_err_q;
  logic                      do_access;

  // Backing store is deliberately never reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                      req;
  logic [1:0]                req_size;
  logic [MEM_ADDR_WIDTH-1:0] raw_addr;
  logic [MEM_ADDR_WIDTH-1:0] req_addr;
  logic                      req_err;
  logic                      unused_addr_hi;

  assign req            = MemReadM | MemWriteM;
  assign req_size       = size_of(funct3M);
  assign raw_addr       = ALUResultM[MEM_ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^ALUResultM[DATA_WIDTH-1:MEM_ADDR_WIDTH];

`ifdef DMEM_MISALIGN_CHK_EN
  assign req_addr = raw_addr;
  assign req_err  = ((req_size == SZ_HALF) && raw_addr[0]) ||
                    ((req_size == SZ_WORD) && (raw_addr[OFFW-1:0] != '0));
`else
  always_comb begin
    req_addr = raw_addr;
    if (req_size == SZ_HALF) req_addr[0] = 1'b0;
    if (req_size == SZ_WORD) req_addr[OFFW-1:0] = '0;
  end
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    store_d   = store_q;
    load_d    = load_q;
    err_d     = err_q;
    StallMem  = 1'b0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          StallMem = 1'b1;
          addr_d   = req_addr;
          wdata_d  = WriteDataM;
          f3_d     = funct3M;
          store_d  = MemWriteM;
          load_d   = MemReadM & ~MemWriteM;
          err_d    = req_err;
          cnt_d    = CNT_INIT;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        StallMem = 1'b1;
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [1:0]            acc_size;
  logic                  acc_unsigned;
  logic [OFFW+2:0]       shamt;
  logic [IDXW-1:0]       acc_idx;
  logic [DATA_WIDTH-1:0] rd_word, rd_sh, load_val;
  logic [DATA_WIDTH-1:0] wr_sh;
  logic [NB-1:0]         wr_be;

  assign acc_size     = size_of(f3_q);
  assign acc_unsigned = (f3_q == FUNCT3_WIDTH'(4)) || (f3_q == FUNCT3_WIDTH'(5));
  assign shamt        = {addr_q[OFFW-1:0], 3'b000};
  assign acc_idx      = addr_q[MEM_ADDR_WIDTH-1:OFFW];
  assign rd_word      = mem_q[acc_idx];
  assign rd_sh        = rd_word >> shamt;
  assign wr_sh        = wdata_q << shamt;

  always_comb begin
    load_val = rd_sh;
    wr_be    = '1;
    case (acc_size)
      SZ_BYTE: begin
        load_val = {{(DATA_WIDTH-8){~acc_unsigned & rd_sh[7]}}, rd_sh[7:0]};
        wr_be    = NB'(1) << addr_q[OFFW-1:0];
      end
      SZ_HALF: begin
        load_val = {{(DATA_WIDTH-16){~acc_unsigned & rd_sh[15]}}, rd_sh[15:0]};
        wr_be    = NB'(3) << addr_q[OFFW-1:0];
      end
      default: begin
        load_val = rd_sh;
        wr_be    = '1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      store_q   <= 1'b0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      store_q   <= store_d;
      load_q    <= load_d;
      err_q     <= err_d;
      mem_err_q <= do_access & err_q;
      if (do_access && load_q && !err_q) rdata_q <= load_val;
    end
  end

  // Reset during WAIT drops the pending store.
  always_ff @(posedge CLK) begin
    if (!RST && do_access && store_q && !err_q) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem_q[acc_idx][b*8 +: 8] <= wr_sh[b*8 +: 8];
      end
    end
  end

  assign ReadDataM = rdata_q;
  assign MemErrM   = mem_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl (LATENCY=2)
module tb_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MemWriteM = 1'b0;
  logic        MemReadM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [2:0]  funct3M = '0;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        MemErrM;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  data_mem_ctrl dut (
    .CLK(CLK), .RST(RST), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .ReadDataM(ReadDataM), .StallMem(StallMem), .MemErrM(MemErrM)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Starts just after a negedge in IDLE; returns stall cycles plus ReadDataM/MemErrM seen in DONE.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output int stalls, output logic [31:0] rd, output logic err);
    MemWriteM = we; MemReadM = re; ALUResultM = addr; WriteDataM = wdata; funct3M = f3;
    #1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      if (!StallMem) break;
      stalls++;
      @(posedge CLK);
      @(negedge CLK);
    end
    rd  = ReadDataM;
    err = MemErrM;
    MemWriteM = 1'b0; MemReadM = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    int s; logic [31:0] rd; logic e;
    access(1'b1, 1'b0, addr, wdata, f3, s, rd, e);
    check_eq({tag, "_stall"}, 32'(s), 32'd3);
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] exp);
    int s; logic [31:0] rd; logic e;
    access(1'b0, 1'b1, addr, 32'h0, f3, s, rd, e);
    check_eq({tag, "_stall"}, 32'(s), 32'd3);
    check_eq(tag, rd, exp);
  endtask

  initial begin
    int s;
    logic [31:0] rd;
    logic e;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_eq("rst_stall", 32'(StallMem), 32'd0);
    check_eq("rst_rdata", ReadDataM, 32'h0);
    check_eq("rst_err", 32'(MemErrM), 32'd0);

    store("sw_100", 32'h100, 32'hDEADBEEF, F_W);
    load("lw_100", 32'h100, F_W, 32'hDEADBEEF);

    store("sw_100_zero", 32'h100, 32'h0, F_W);
    store("sb_101", 32'h101, 32'h12345680, F_B);
    load("lb_101", 32'h101, F_B, 32'hFFFFFF80);
    load("lbu_101", 32'h101, F_BU, 32'h00000080);
    load("lw_100_b", 32'h100, F_W, 32'h00008000);

    store("sw_200", 32'h200, 32'h11223344, F_W);
    store("sh_202", 32'h202, 32'hABCD8001, F_H);
    load("lh_202", 32'h202, F_H, 32'hFFFF8001);
    load("lhu_202", 32'h202, F_HU, 32'h00008001);
    load("lw_200", 32'h200, F_W, 32'h80013344);

    // Reset during WAIT aborts the store.
    store("sw_300_zero", 32'h300, 32'h0, F_W);
    MemWriteM = 1'b1; ALUResultM = 32'h300; WriteDataM = 32'h12345678; funct3M = F_W;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("abort_in_wait", 32'(StallMem), 32'd1);
    RST = 1'b1; MemWriteM = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_eq("abort_stall", 32'(StallMem), 32'd0);
    check_eq("abort_rdata", ReadDataM, 32'h0);
    load("lw_300", 32'h300, F_W, 32'h0);

    store("sw_40", 32'h40, 32'h11, F_W);
    load("lw_40", 32'h40, F_W, 32'h11);
    access(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5, F_W, s, rd, e);
    check_eq("rw_stall", 32'(s), 32'd3);
    check_eq("rw_rdata_done", rd, 32'h11);
    check_eq("rw_rdata_after", ReadDataM, 32'h11);
    load("lw_alias", 32'h20010, F_W, 32'hA5A5A5A5);

    store("sw_100_c", 32'h100, 32'hCAFEF00D, F_W);
    access(1'b0, 1'b1, 32'h102, 32'h0, F_W, s, rd, e);
    check_eq("mis_stall", 32'(s), 32'd3);
`ifdef DMEM_MISALIGN_CHK_EN
    check_eq("mis_err_done", 32'(e), 32'd1);
    check_eq("mis_rdata", rd, 32'hA5A5A5A5);
`else
    check_eq("mis_err_done", 32'(e), 32'd0);
    check_eq("mis_rdata", rd, 32'hCAFEF00D);
`endif
    check_eq("mis_err_after", 32'(MemErrM), 32'd0);

    #1;
    check_eq("idle_stall", 32'(StallMem), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
